// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one calculator ALU between NumReq requesters, one operation in flight.
// Optional watchdog on the ALU handshakes: define ALU_ARB_TIMEOUT_EN.

package calc_pkg;
   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_t;

   typedef struct packed {
      logic        error;
      logic [15:0] value;
   } num_t;
endpackage

module alu_arbiter #(
   parameter int unsigned NumReq        = 2,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  calc_pkg::num_t              req_left_i  [NumReq],
   input  calc_pkg::num_t              req_right_i [NumReq],
   input  calc_pkg::op_t               req_op_i    [NumReq],
   input  logic [NumReq-1:0]           req_in_valid_i,
   output logic [NumReq-1:0]           req_in_ready_o,
   output calc_pkg::num_t              req_result_o,
   output logic [NumReq-1:0]           req_out_valid_o,
   input  logic [NumReq-1:0]           req_out_ready_i,
   output calc_pkg::num_t              alu_left_o,
   output calc_pkg::num_t              alu_right_o,
   output calc_pkg::op_t               alu_op_o,
   output logic                        alu_in_valid_o,
   input  logic                        alu_in_ready_i,
   input  calc_pkg::num_t              alu_result_i,
   input  logic                        alu_out_valid_i,
   output logic                        alu_out_ready_o,
   output logic [$clog2(NumReq)-1:0]   grant_o,
   output logic                        busy_o
);
   import calc_pkg::*;

   localparam int unsigned IdxW = $clog2(NumReq);
   typedef logic [IdxW-1:0] idx_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DELIVER
   } state_e;

   state_e            state_q;
   idx_t              rr_ptr_q;
   idx_t              grant_q;
   num_t              left_q;
   num_t              right_q;
   op_t               op_q;
   num_t              result_q;
   logic              alu_in_valid_q;
   logic              alu_out_ready_q;
   logic [NumReq-1:0] out_valid_q;

   logic              pick_found;
   idx_t              pick_idx;
   idx_t              rr_ptr_d;
   logic [NumReq-1:0] pick_oh;
   logic [NumReq-1:0] grant_oh;

   // First valid requester at or above rr_ptr_q, wrapping modulo NumReq.
   always_comb begin : pick_search
      idx_t cand;
      cand       = '0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         cand = idx_t'((32'(rr_ptr_q) + i) % NumReq);
         if (!pick_found && req_in_valid_i[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign rr_ptr_d = idx_t'((32'(grant_q) + 32'd1) % NumReq);
   assign pick_oh  = {{(NumReq-1){1'b0}}, 1'b1} << pick_idx;
   assign grant_oh = {{(NumReq-1){1'b0}}, 1'b1} << grant_q;

   assign req_in_ready_o  = (state_q == S_IDLE && pick_found) ? pick_oh : '0;
   assign req_result_o    = result_q;
   assign req_out_valid_o = out_valid_q;
   assign alu_left_o      = left_q;
   assign alu_right_o     = right_q;
   assign alu_op_o        = op_q;
   assign alu_in_valid_o  = alu_in_valid_q;
   assign alu_out_ready_o = alu_out_ready_q;
   assign grant_o         = grant_q;
   assign busy_o          = (state_q != S_IDLE);

`ifdef ALU_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   localparam num_t TmoResult = '{error: 1'b1, value: '0};

   logic [CntW-1:0] tmo_cnt_q;
   logic            tmo_hit;

   assign tmo_hit = (tmo_cnt_q == CntW'(TimeoutCycles - 1));
`else
   // The watchdog limit has no effect when the watchdog is not built.
   if (TimeoutCycles == 0) begin : g_tmo_unused
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= S_IDLE;
         rr_ptr_q        <= '0;
         grant_q         <= '0;
         left_q          <= '0;
         right_q         <= '0;
         op_q            <= OP_ADD;
         result_q        <= '0;
         alu_in_valid_q  <= 1'b0;
         alu_out_ready_q <= 1'b0;
         out_valid_q     <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
         tmo_cnt_q       <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_found) begin
                  left_q         <= req_left_i[pick_idx];
                  right_q        <= req_right_i[pick_idx];
                  op_q           <= req_op_i[pick_idx];
                  grant_q        <= pick_idx;
                  alu_in_valid_q <= 1'b1;
                  state_q        <= S_ISSUE;
`ifdef ALU_ARB_TIMEOUT_EN
                  tmo_cnt_q      <= '0;
`endif
               end
            end
            S_ISSUE: begin
`ifdef ALU_ARB_TIMEOUT_EN
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
               if (alu_in_ready_i) begin
                  alu_in_valid_q  <= 1'b0;
                  alu_out_ready_q <= 1'b1;
                  state_q         <= S_WAIT;
               end
`ifdef ALU_ARB_TIMEOUT_EN
               else if (tmo_hit) begin
                  alu_in_valid_q <= 1'b0;
                  result_q       <= TmoResult;
                  out_valid_q    <= grant_oh;
                  state_q        <= S_DELIVER;
               end
`endif
            end
            S_WAIT: begin
`ifdef ALU_ARB_TIMEOUT_EN
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
               if (alu_out_valid_i) begin
                  result_q        <= alu_result_i;
                  alu_out_ready_q <= 1'b0;
                  out_valid_q     <= grant_oh;
                  state_q         <= S_DELIVER;
               end
`ifdef ALU_ARB_TIMEOUT_EN
               else if (tmo_hit) begin
                  alu_out_ready_q <= 1'b0;
                  result_q        <= TmoResult;
                  out_valid_q     <= grant_oh;
                  state_q         <= S_DELIVER;
               end
`endif
            end
            S_DELIVER: begin
               if (req_out_ready_i[grant_q]) begin
                  out_valid_q <= '0;
                  rr_ptr_q    <= rr_ptr_d;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: queue-driven requesters, delay-configurable ALU, transaction-level reference model.
// Builds with or without ALU_ARB_TIMEOUT_EN.

module tb_alu_arbiter;
   import calc_pkg::*;

   localparam int unsigned N = 2;
`ifdef ALU_ARB_TIMEOUT_EN
   localparam int unsigned TMO = 10;
`else
   localparam int unsigned TMO = 255;
`endif

   typedef struct packed {
      num_t l;
      num_t r;
      op_t  op;
   } job_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   num_t              req_left [N];
   num_t              req_right[N];
   op_t               req_op   [N];
   logic [N-1:0]      req_in_valid, req_in_ready, req_out_valid, req_out_ready;
   num_t              req_result, alu_left, alu_right, alu_result;
   op_t               alu_op;
   logic              alu_in_valid, alu_in_ready, alu_out_valid, alu_out_ready, busy;
   logic [$clog2(N)-1:0] grant;

   alu_arbiter #(.NumReq(N), .TimeoutCycles(TMO)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_left_i     (req_left),
      .req_right_i    (req_right),
      .req_op_i       (req_op),
      .req_in_valid_i (req_in_valid),
      .req_in_ready_o (req_in_ready),
      .req_result_o   (req_result),
      .req_out_valid_o(req_out_valid),
      .req_out_ready_i(req_out_ready),
      .alu_left_o     (alu_left),
      .alu_right_o    (alu_right),
      .alu_op_o       (alu_op),
      .alu_in_valid_o (alu_in_valid),
      .alu_in_ready_i (alu_in_ready),
      .alu_result_i   (alu_result),
      .alu_out_valid_i(alu_out_valid),
      .alu_out_ready_o(alu_out_ready),
      .grant_o        (grant),
      .busy_o         (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic num_t calc(input num_t l, input num_t r, input op_t op);
      num_t res;
      res = '0;
      case (op)
         OP_ADD: res.value = l.value + r.value;
         OP_SUB: res.value = l.value - r.value;
         OP_MUL: res.value = 16'(l.value * r.value);
         OP_DIV: begin
            if (r.value == 16'd0) res.error = 1'b1;
            else res.value = l.value / r.value;
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   function automatic job_t mk(input int l, input int r, input op_t op);
      job_t j;
      j = '0;
      j.l.value = 16'(l);
      j.r.value = 16'(r);
      j.op = op;
      return j;
   endfunction

   // Bench ALU: handshakes appear after configurable numbers of cycles.
   int unsigned in_delay = 0, out_delay = 0, rdy_delay = 0;
   int unsigned in_cnt = 0, out_cnt = 0, rdy_cnt = 0;
   logic [N-1:0] rdy_force = '0;

   always @(posedge clk) begin
      in_cnt  <= alu_in_valid  ? in_cnt + 1  : 0;
      out_cnt <= alu_out_ready ? out_cnt + 1 : 0;
      rdy_cnt <= (req_out_valid != '0) ? rdy_cnt + 1 : 0;
   end

   assign alu_in_ready  = (in_cnt >= in_delay);
   assign alu_out_valid = (out_cnt >= out_delay);
   assign alu_result    = calc(alu_left, alu_right, alu_op);
   assign req_out_ready = {N{rdy_cnt >= rdy_delay}} | rdy_force;

   // Requesters: each presents the head of its job queue until accepted.
   job_t q0[$];
   job_t q1[$];

   initial begin
      logic [N-1:0] acc;
      req_in_valid = '0;
      for (int i = 0; i < N; i++) begin
         req_left[i] = '0; req_right[i] = '0; req_op[i] = OP_ADD;
      end
      forever begin
         @(negedge clk);
         acc = req_in_ready & req_in_valid;
         @(posedge clk);
         #1;
         if (acc[0] && q0.size() > 0) void'(q0.pop_front());
         if (acc[1] && q1.size() > 0) void'(q1.pop_front());
         req_in_valid[0] = (q0.size() > 0);
         if (q0.size() > 0) begin
            req_left[0] = q0[0].l; req_right[0] = q0[0].r; req_op[0] = q0[0].op;
         end
         req_in_valid[1] = (q1.size() > 0);
         if (q1.size() > 0) begin
            req_left[1] = q1[0].l; req_right[1] = q1[0].r; req_op[1] = q1[0].op;
         end
      end
   end

   // Reference model: one job in flight, round-robin pointer, result computed from the accepted payload.
   int   m_rr = 0, m_g = 0, m_in_hs = 0, m_out_hs = 0, deliv_cnt = 0;
   bit   m_busy = 0;
   job_t m_job;
   int   glog[$];
   num_t rlog[$];

   initial begin
      logic [N-1:0] exp_rdy;
      int g, idx, phases;
      num_t exp_res;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_rr = 0;
            m_busy = 0;
            chk("reset_outputs",
                {req_in_ready, req_out_valid, alu_in_valid, alu_out_ready, busy, grant,
                 alu_left, alu_right, req_result, alu_op},
                {59'd0, OP_ADD});
         end else begin
            exp_rdy = '0;
            g = 0;
            if (!m_busy) begin
               for (int i = N - 1; i >= 0; i--) begin
                  idx = (m_rr + i) % N;
                  if (req_in_valid[idx]) g = idx;
               end
               if (req_in_valid != '0) exp_rdy[g] = 1'b1;
            end
            chk("in_ready", req_in_ready, exp_rdy);
            chk("busy", busy, m_busy);
            if (m_busy) begin
               phases = int'(alu_in_valid) + int'(alu_out_ready) + int'(req_out_valid != '0);
               chk("operands_stable", {alu_left, alu_right, alu_op}, m_job);
               chk("grant", grant, m_g);
               chk("phase_exclusive", phases <= 1, 1);
               chk("out_valid_target", req_out_valid & ~(N'(1) << m_g), 0);
               if (alu_in_valid && alu_in_ready) m_in_hs++;
               if (alu_out_ready && alu_out_valid) m_out_hs++;
               if (req_out_valid[m_g] && req_out_ready[m_g]) begin
                  exp_res = (m_out_hs == 1) ? calc(m_job.l, m_job.r, m_job.op) : '{error: 1'b1, value: 16'd0};
                  chk("result", req_result, exp_res);
                  chk("alu_tx_once", (m_in_hs <= 1) && (m_out_hs <= 1) && (m_out_hs <= m_in_hs), 1);
                  glog.push_back(m_g);
                  rlog.push_back(req_result);
                  deliv_cnt++;
                  m_busy = 0;
                  m_rr = (m_g + 1) % N;
               end
            end else begin
               chk("idle_handshakes", {alu_in_valid, alu_out_ready, req_out_valid}, 0);
               if (exp_rdy != '0) begin
                  m_busy = 1;
                  m_g = g;
                  m_job = {req_left[g], req_right[g], req_op[g]};
                  m_in_hs = 0;
                  m_out_hs = 0;
               end
            end
         end
      end
   end

   task automatic wait_accept(input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_in_ready != '0) break;
      end
      chk(name, req_in_ready != '0, 1);
   endtask

   task automatic wait_deliv(input string name, input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (deliv_cnt >= target) break;
         @(negedge clk);
         #1;
      end
      chk(name, deliv_cnt >= target, 1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int d0, n;
      logic [3:0] ord;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_alu_op", alu_op, OP_ADD);
      #1 rst_n = 1'b1;

      // Single request, zero-delay ALU: 2 + 3 delivered at cycle 3.
      q0.push_back(mk(2, 3, OP_ADD));
      wait_accept("t1_accept_wait");
      chk("t1_accept_c0", req_in_ready, 2'b01);
      @(negedge clk);
      chk("t1_in_valid_c1", alu_in_valid, 1);
      @(negedge clk);
      chk("t1_out_ready_c2", alu_out_ready, 1);
      @(negedge clk);
      chk("t1_out_valid_c3", req_out_valid, 2'b01);
      chk("t1_result_c3", req_result, {1'b0, 16'd5});
      @(negedge clk);
      chk("t1_idle_c4", busy, 0);

      // Contention from reset: order 0,1,0,1.
      do_reset();
      glog.delete();
      rlog.delete();
      d0 = deliv_cnt;
      q0.push_back(mk(10, 4, OP_SUB));
      q0.push_back(mk(7, 6, OP_MUL));
      q1.push_back(mk(100, 7, OP_DIV));
      q1.push_back(mk(9, 0, OP_DIV));
      wait_deliv("t2_deliveries", d0 + 4, 200);
      ord = (glog.size() == 4) ? {glog[0][0], glog[1][0], glog[2][0], glog[3][0]} : 4'hF;
      chk("t2_grant_order", ord, 4'b0101);
      chk("t2_div_result", (rlog.size() == 4) ? rlog[1] : '1, {1'b0, 16'd14});
      chk("t2_div0_result", (rlog.size() == 4) ? rlog[3] : '0, {1'b1, 16'd0});

      // One persistent requester is re-granted every time.
      glog.delete();
      rlog.delete();
      d0 = deliv_cnt;
      q1.push_back(mk(1, 1, OP_ADD));
      q1.push_back(mk(2, 2, OP_ADD));
      q1.push_back(mk(3, 3, OP_MUL));
      wait_deliv("t3_deliveries", d0 + 3, 200);
      ord = (glog.size() == 3) ? {1'b0, glog[0][0], glog[1][0], glog[2][0]} : 4'hF;
      chk("t3_grant_order", ord, 4'b0111);
      chk("t3_mul_result", (rlog.size() == 3) ? rlog[2] : '1, {1'b0, 16'd9});

      // Backpressure on every handshake; requester 1's ready must be ignored.
      in_delay = 4; out_delay = 6; rdy_delay = 3; rdy_force = 2'b10;
      d0 = deliv_cnt;
      q0.push_back(mk(20, 22, OP_ADD));
      wait_accept("t4_accept_wait");
      n = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         #1;
         n = i;
         if (deliv_cnt > d0) break;
      end
      chk("t4_latency", n, 16);
      chk("t4_one_delivery", deliv_cnt - d0, 1);
      chk("t4_result", req_result, {1'b0, 16'd42});
      in_delay = 0; out_delay = 0; rdy_delay = 0; rdy_force = '0;

      // Asynchronous reset while waiting for the ALU result.
      out_delay = 3;
      q0.push_back(mk(5, 5, OP_ADD));
      wait_accept("t5_accept_wait");
      @(negedge clk);
      @(negedge clk);
      chk("t5_in_wait", alu_out_ready, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_reset_ctrl", {busy, alu_out_ready, alu_in_valid, req_out_valid, req_in_ready}, 0);
      chk("t5_reset_data", {alu_left, alu_right, req_result}, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      out_delay = 0;
      d0 = deliv_cnt;
      q1.push_back(mk(8, 8, OP_SUB));
      wait_accept("t5_reaccept_wait");
      chk("t5_reaccept", req_in_ready, 2'b10);
      wait_deliv("t5_delivery", d0 + 1, 50);
      chk("t5_result", req_result, {1'b0, 16'd0});

      // ALU never accepts.
      in_delay = 100000;
      q0.push_back(mk(1, 2, OP_ADD));
      wait_accept("t6_accept_wait");
`ifdef ALU_ARB_TIMEOUT_EN
      repeat (10) @(negedge clk);
      chk("t6_still_issue", {alu_in_valid, req_out_valid}, 3'b100);
      @(negedge clk);
      chk("t6_timeout_valid", {alu_in_valid, req_out_valid}, 3'b001);
      chk("t6_timeout_result", req_result, {1'b1, 16'd0});
      in_delay = 0;
      @(negedge clk);
`else
      repeat (1000) @(negedge clk);
      chk("t6_stuck_issue", {busy, alu_in_valid, req_out_valid}, 4'b1100);
      do_reset();
      in_delay = 0;
`endif
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single calculator ALU between up to `NumReq` independent requesters, such as the keypad controller and a memory/recall unit. It accepts one operation at a time, selected by round-robin. It registers the operands, drives the ALU valid/ready handshake, and returns the result to the granted requester on its own valid/ready output channel. It sits between the requester blocks and the ALU, and only one operation is ever outstanding.

## Interface
Parameters:
- `NumReq`, default 2: number of requesters (2–8).
- `TimeoutCycles`, default 255: watchdog limit. Used only with `ALU_ARB_TIMEOUT_EN`.

Ports:
- `clk_i`  input  1  clock.
- `rst_ni`  input  1  reset. One clock; asynchronous, active-low.
- `req_left_i[NumReq]`  input  calc_pkg::num_t  left operand per requester.
- `req_right_i[NumReq]`  input  calc_pkg::num_t  right operand per requester.
- `req_op_i[NumReq]`  input  calc_pkg::op_t  operation per requester.
- `req_in_valid_i`  input  NumReq  operation request per requester.
- `req_in_ready_o`  output  NumReq  acceptance strobe, one-hot.
- `req_result_o`  output  calc_pkg::num_t  result register, broadcast to all requesters.
- `req_out_valid_o`  output  NumReq  result valid, one-hot to the granted requester.
- `req_out_ready_i`  input  NumReq  requester result ready.
- `alu_left_o`, `alu_right_o`  output  calc_pkg::num_t  registered operands.
- `alu_op_o`  output  calc_pkg::op_t  registered operation.
- `alu_in_valid_o`  output  1  ALU input valid.
- `alu_in_ready_i`  input  1  ALU input ready.
- `alu_result_i`  input  calc_pkg::num_t  ALU result.
- `alu_out_valid_i`  input  1  ALU result valid.
- `alu_out_ready_o`  output  1  ALU result ready.
- `grant_o`  output  $clog2(NumReq)  index of the current or last grant.
- `busy_o`  output  1  high in any state other than S_IDLE.

## Operation
- FSM states are S_IDLE, S_ISSUE, S_WAIT, S_DELIVER.
- **S_IDLE**
  - If any `req_in_valid_i` bit is set, grant the first set bit found by searching upward from `rr_ptr`, wrapping modulo `NumReq`.
  - `req_in_ready_o[g]` is asserted combinationally in that cycle.
  - Capture `req_left_i[g]`, `req_right_i[g]` and `req_op_i[g]`, set `grant_o`=g, and go to S_ISSUE.
- **S_ISSUE**
  - `alu_in_valid_o`=1.
  - On `alu_in_ready_i`, go to S_WAIT.
- **S_WAIT**
  - `alu_out_ready_o`=1.
  - On `alu_out_valid_i`, register `alu_result_i` into `req_result_o` and go to S_DELIVER.
- **S_DELIVER**
  - `req_out_valid_o[g]`=1.
  - On `req_out_ready_i[g]`, set `rr_ptr`=(g+1) mod `NumReq` and go to S_IDLE.
- Operands stay stable on `alu_*_o` from acceptance until the next acceptance.
- Requesters must hold valid and payload until ready is returned. The arbiter does not depend on the payload after the acceptance cycle.
- `req_in_ready_o` is all zero outside S_IDLE.
- Requests arriving while busy wait. No request is dropped.
- Ready bits from non-granted requesters are ignored.

## Timing
- Reset values:
  - all `*_valid_o`, `*_ready_o` and `busy_o` = 0
  - `alu_left_o`, `alu_right_o`, `req_result_o` = '0
  - `alu_op_o` = OP_ADD, `grant_o` = 0, `rr_ptr` = 0, state = S_IDLE
- Minimum latency, with the ALU ready and valid immediately: accept at cycle 0, `alu_in_valid_o` at 1, `alu_out_ready_o` at 2, `req_out_valid_o` at 3.
- Next acceptance is possible no earlier than the cycle after the delivery handshake.
- Simultaneous requests: exactly one grant per acceptance, in round-robin order. A single persistent requester is re-granted every transaction.
- Asynchronous reset mid-operation discards the in-flight operation and returns every output to its reset value immediately. The ALU must be reset alongside.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - A counter runs during S_ISSUE and S_WAIT and clears on entry to S_ISSUE.
  - When it reaches `TimeoutCycles` without the state's handshake completing:
    - deassert `alu_in_valid_o` and `alu_out_ready_o`;
    - load `req_result_o` with '0 and `error`=1;
    - go to S_DELIVER.
- Not defined: no counter; the arbiter waits indefinitely. `TimeoutCycles` is unused.

## Test plan
- Single request: requester 0 sends 2+3, ALU ready and valid immediately → accept at cycle 0; `req_out_valid_o`=2'b01 with the result 5 at cycle 3.
- Contention: both requesters valid in the same cycle from reset → requester 0 granted first, then requester 1. Repeating with both still valid → order 0,1,0,1.
- Backpressure: ALU `in_ready` delayed 4 cycles and `out_valid` delayed 6, requester `out_ready` delayed 3 → operands stable throughout, exactly one ALU transaction, one result delivered.
- Reset mid-operation: deassert `rst_ni` in S_WAIT → all outputs 0 in the same cycle; after release, a fresh request is accepted normally.
- Timeout (macro defined, `TimeoutCycles`=10): ALU never raises `in_ready` → at cycle 10 of S_ISSUE, `req_out_valid_o` is set with `req_result_o.error`=1; without the macro, still in S_ISSUE after 1000 cycles.
